// File: rtl/exp_bf16_pipe.sv
// exp_bf16_pipe: LANES-wide, 3-stage piecewise-linear BF16 exp(x) with valid/ready on both sides.
// Optional feature macro: EXP_NAN_PROP_EN (NaN lanes -> 0x7FC0 instead of the sign-dependent big result).
module exp_bf16_pipe #(
  parameter int LANES = 4,
  parameter int EMIN  = -7,
  parameter int EMAX  = 6,
  parameter int TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*16-1:0]  in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*16-1:0]  out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam logic [7:0] E_LO = 8'(127 + EMIN);
  localparam logic [7:0] E_HI = 8'(127 + EMAX);

  // Segment start values: BF16 bit pattern of exp(+-2^e), e = EMIN + idx.
  function automatic logic [15:0] lut_base(input logic s, input logic [7:0] idx);
    logic [15:0] b;
    if (s == 1'b0) begin
      case (idx)
        8'd0:    b = 16'h3F81;
        8'd1:    b = 16'h3F82;
        8'd2:    b = 16'h3F84;
        8'd3:    b = 16'h3F88;
        8'd4:    b = 16'h3F91;
        8'd5:    b = 16'h3FA4;
        8'd6:    b = 16'h3FD3;
        8'd7:    b = 16'h402E;
        8'd8:    b = 16'h40EC;
        8'd9:    b = 16'h425A;
        8'd10:   b = 16'h453A;
        8'd11:   b = 16'h4B08;
        8'd12:   b = 16'h5690;
        default: b = 16'h0000;
      endcase
    end else begin
      case (idx)
        8'd0:    b = 16'h3F7E;
        8'd1:    b = 16'h3F7C;
        8'd2:    b = 16'h3F78;
        8'd3:    b = 16'h3F70;
        8'd4:    b = 16'h3F62;
        8'd5:    b = 16'h3F47;
        8'd6:    b = 16'h3F1B;
        8'd7:    b = 16'h3EBC;
        8'd8:    b = 16'h3E0B;
        8'd9:    b = 16'h3C96;
        8'd10:   b = 16'h39B0;
        8'd11:   b = 16'h33F2;
        8'd12:   b = 16'h2864;
        default: b = 16'h0000;
      endcase
    end
    return b;
  endfunction

  // Segment slopes in bit-pattern units per full mantissa span; negative side is two's complement.
  function automatic logic [25:0] lut_off(input logic s, input logic [7:0] idx);
    logic [25:0] o;
    if (s == 1'b0) begin
      case (idx)
        8'd0:    o = 26'h0000001;
        8'd1:    o = 26'h0000002;
        8'd2:    o = 26'h0000004;
        8'd3:    o = 26'h0000009;
        8'd4:    o = 26'h0000013;
        8'd5:    o = 26'h000002F;
        8'd6:    o = 26'h000005B;
        8'd7:    o = 26'h00000BE;
        8'd8:    o = 26'h000016E;
        8'd9:    o = 26'h00002E0;
        8'd10:   o = 26'h00005CE;
        8'd11:   o = 26'h0000B88;
        8'd12:   o = 26'h0001711;
        default: o = 26'h0000000;
      endcase
    end else begin
      case (idx)
        8'd0:    o = 26'h3FFFFFE;
        8'd1:    o = 26'h3FFFFFC;
        8'd2:    o = 26'h3FFFFF8;
        8'd3:    o = 26'h3FFFFF2;
        8'd4:    o = 26'h3FFFFE5;
        8'd5:    o = 26'h3FFFFD4;
        8'd6:    o = 26'h3FFFFA1;
        8'd7:    o = 26'h3FFFF4F;
        8'd8:    o = 26'h3FFFE8B;
        8'd9:    o = 26'h3FFFD1A;
        8'd10:   o = 26'h3FFFA42;
        8'd11:   o = 26'h3FFF472;
        8'd12:   o = 26'h3FFE8E7;
        default: o = 26'h0000000;
      endcase
    end
    return o;
  endfunction

  // Returns {special, value}; special lanes bypass the interpolation.
  function automatic logic [16:0] lane_special(input logic [15:0] x);
    logic [16:0] r;
    logic        is_nan;
`ifdef EXP_NAN_PROP_EN
    is_nan = (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
`else
    is_nan = 1'b0;
`endif
    if (is_nan) begin
      r = {1'b1, 16'h7FC0};
    end else if (x[14:7] >= E_HI) begin
      r = {1'b1, 1'b0, {8{~x[15]}}, 7'd0};
    end else if (x[14:7] < E_LO) begin
      r = {1'b1, 16'h3F80};
    end else begin
      r = {1'b0, 16'h0000};
    end
    return r;
  endfunction

  logic                   adv_s;
  logic                   v1_r, v2_r, v3_r;
  logic [TAG_W-1:0]       tag1_r, tag2_r, tag3_r;
  logic [LANES-1:0][16:0] spec_s, spec1_r, spec2_r;
  logic [LANES-1:0][15:0] base_s, base1_r, base2_r;
  logic [LANES-1:0][25:0] off_s, off1_r;
  logic [LANES-1:0][6:0]  m_s, m1_r;
  logic [LANES-1:0][32:0] prod2_r;
  logic [LANES-1:0][15:0] y_s;
  logic [LANES*16-1:0]    data3_r;
  logic                   unused_prod_s;

  assign adv_s     = ~v3_r | out_ready;
  assign in_ready  = adv_s;
  assign out_valid = v3_r;
  assign out_data  = data3_r;
  assign out_tag   = tag3_r;
  assign busy      = v1_r | v2_r | v3_r;

  // Stage-1 lookup: classify each lane and fetch its segment base/slope.
  always_comb begin
    spec_s = '0;
    base_s = '0;
    off_s  = '0;
    m_s    = '0;
    for (int i = 0; i < LANES; i++) begin
      spec_s[i] = lane_special(in_data[16*i +: 16]);
      base_s[i] = lut_base(in_data[16*i+15], in_data[16*i+7 +: 8] - E_LO);
      off_s[i]  = lut_off(in_data[16*i+15], in_data[16*i+7 +: 8] - E_LO);
      m_s[i]    = in_data[16*i +: 7];
    end
  end

  // Stage 1 register: captured vector, class and segment parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r    <= 1'b0;
      tag1_r  <= '0;
      spec1_r <= '0;
      base1_r <= '0;
      off1_r  <= '0;
      m1_r    <= '0;
    end else if (adv_s) begin
      v1_r    <= in_valid;
      tag1_r  <= in_tag;
      spec1_r <= spec_s;
      base1_r <= base_s;
      off1_r  <= off_s;
      m1_r    <= m_s;
    end
  end

  // Stage 2 register: full M*slope products (slope sign handled by modular arithmetic).
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r    <= 1'b0;
      tag2_r  <= '0;
      spec2_r <= '0;
      base2_r <= '0;
      prod2_r <= '0;
    end else if (adv_s) begin
      v2_r    <= v1_r;
      tag2_r  <= tag1_r;
      spec2_r <= spec1_r;
      base2_r <= base1_r;
      for (int i = 0; i < LANES; i++) begin
        prod2_r[i] <= {26'd0, m1_r[i]} * {7'd0, off1_r[i]};
      end
    end
  end

  // Stage-3 result: 16-bit wrapping add, then the special-class override.
  always_comb begin
    y_s           = '0;
    unused_prod_s = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (spec2_r[i][16]) begin
        y_s[i] = spec2_r[i][15:0];
      end else begin
        y_s[i] = base2_r[i] + prod2_r[i][22:7];
      end
      unused_prod_s = unused_prod_s ^ (^prod2_r[i][32:23]) ^ (^prod2_r[i][6:0]);
    end
  end

  // Stage 3 register: output vector, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_r    <= 1'b0;
      tag3_r  <= '0;
      data3_r <= '0;
    end else if (adv_s) begin
      v3_r    <= v2_r;
      tag3_r  <= tag2_r;
      for (int i = 0; i < LANES; i++) begin
        data3_r[16*i +: 16] <= y_s[i];
      end
    end
  end

endmodule

// File: tb/tb_exp_bf16_pipe.sv
// Self-checking bench for exp_bf16_pipe: reference model built from the lane rules plus an in-order scoreboard.
module tb_exp_bf16_pipe;
  localparam int LANES = 4;
  localparam int EMIN  = -7;
  localparam int EMAX  = 6;
  localparam int TAG_W = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [LANES*16-1:0] in_data = '0;
  logic [TAG_W-1:0]    in_tag = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [LANES*16-1:0] out_data;
  logic [TAG_W-1:0]    out_tag;
  logic                busy;

  exp_bf16_pipe #(.LANES(LANES), .EMIN(EMIN), .EMAX(EMAX), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Segment tables: exp(+-2^e) as BF16 bits, slope = next segment start minus this one.
  int base_tab [0:1][0:12] = '{
    '{'h3F81, 'h3F82, 'h3F84, 'h3F88, 'h3F91, 'h3FA4, 'h3FD3, 'h402E, 'h40EC, 'h425A, 'h453A, 'h4B08, 'h5690},
    '{'h3F7E, 'h3F7C, 'h3F78, 'h3F70, 'h3F62, 'h3F47, 'h3F1B, 'h3EBC, 'h3E0B, 'h3C96, 'h39B0, 'h33F2, 'h2864}};
  int off_tab [0:1][0:12] = '{
    '{1, 2, 4, 9, 19, 47, 91, 190, 366, 736, 1486, 2952, 5905},
    '{-2, -4, -8, -14, -27, -44, -95, -177, -373, -742, -1470, -2958, -5913}};

  int tests = 0;
  int fails = 0;
  int out_count = 0;
  logic [TAG_W-1:0] tag_ctr = '0;
  logic [TAG_W+63:0] exp_q [$];
  logic have_hold = 1'b0;
  logic [63:0] hold_data;
  logic [TAG_W-1:0] hold_tag;

  function automatic logic [15:0] model_lane(input logic [15:0] x);
    int s, e, m, idx, p, y;
    s = int'(x[15]);
    e = int'(x[14:7]);
    m = int'(x[6:0]);
`ifdef EXP_NAN_PROP_EN
    if (e == 255 && m != 0) return 16'h7FC0;
`endif
    if (e >= 127 + EMAX) return (s == 1) ? 16'h0000 : 16'h7F80;
    if (e < 127 + EMIN) return 16'h3F80;
    idx = e - (127 + EMIN);
    p = (m * off_tab[s][idx]) >>> 7;
    y = base_tab[s][idx] + p;
    return 16'(y);
  endfunction

  function automatic logic [63:0] model_vec(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[16*i +: 16] = model_lane(d[16*i +: 16]);
    return r;
  endfunction

  function automatic logic [15:0] gen_lane();
    int r;
    logic [7:0] e;
    r = $urandom_range(0, 15);
    if (r == 0) return 16'($urandom);
    if (r == 1) e = 8'hFF;
    else if (r == 2) e = 8'($urandom_range(118, 121));
    else if (r == 3) e = 8'($urandom_range(131, 134));
    else e = 8'($urandom_range(110, 140));
    return {1'($urandom), e, 7'($urandom)};
  endfunction

  function automatic logic [63:0] gen_vec();
    return {gen_lane(), gen_lane(), gen_lane(), gen_lane()};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: push model results on accept, pop and compare on emit, check handshake and hold.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      have_hold = 1'b0;
    end else begin
      check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (have_hold) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", out_data, hold_data);
        check("stall_tag", 64'(out_tag), 64'(hold_tag));
      end
      have_hold = out_valid && !out_ready;
      hold_data = out_data;
      hold_tag  = out_tag;
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(out_tag), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [TAG_W+63:0] ev;
          ev = exp_q.pop_front();
          check("out_data", out_data, ev[63:0]);
          check("out_tag", 64'(out_tag), 64'(ev[TAG_W+63:64]));
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_tag, model_vec(in_data)});
    end
  end

  // Present one vector until accepted; rmode 0=ready high, 1=ready low, 2=toggle, 3=random with gaps.
  task automatic drive_vec(input logic [63:0] d, input int rmode);
    int guard;
    logic acc;
    guard = 0;
    acc = 1'b0;
    if (rmode == 3 && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data = d;
    in_tag = tag_ctr;
    while (!acc && guard < 200) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        2:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom);
      endcase
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (acc) tag_ctr++;
    else check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int lat, acc, c0;
    logic [63:0] svec [0:5];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);

    check("pin_one", 64'(model_lane(16'h3F80)), 64'h402E);
    check("pin_neg_one", 64'(model_lane(16'hBF80)), 64'h3EBC);
    check("pin_1p5", 64'(model_lane(16'h3FC0)), 64'h408D);
    check("pin_neg_1p5", 64'(model_lane(16'hBFC0)), 64'h3E63);
    check("pin_top_seg", 64'(model_lane(16'h427F)), 64'h6D72);
    check("pin_small", 64'(model_lane(16'h3000)), 64'h3F80);
`ifdef EXP_NAN_PROP_EN
    check("pin_nan_pos", 64'(model_lane(16'h7FC1)), 64'h7FC0);
    check("pin_nan_neg", 64'(model_lane(16'hFFC1)), 64'h7FC0);
`else
    check("pin_nan_pos", 64'(model_lane(16'h7FC1)), 64'h7F80);
    check("pin_nan_neg", 64'(model_lane(16'hFFC1)), 64'h0000);
`endif

    // Latency and the canonical class vector.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = {16'hC300, 16'h4300, 16'h3000, 16'h0000};
    in_tag = 8'hA5;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 64'(lat), 64'd3);
    check("class_vec", out_data, {16'h0000, 16'h7F80, 16'h3F80, 16'h3F80});
    check("class_tag", 64'(out_tag), 64'hA5);
    @(posedge clk); #1;
    drain();

    // Mantissa sweep over both signs of the x=1 segment and the top segment.
    for (int m = 0; m < 128; m++) begin
      drive_vec({1'b1, 8'h84, 7'(m), 1'b0, 8'h84, 7'(m), 1'b1, 8'h7F, 7'(m), 1'b0, 8'h7F, 7'(m)}, 0);
    end
    drive_vec({16'hFFC1, 16'h7FC1, 16'hBF80, 16'h3F80}, 0);
    drive_vec({16'hFF80, 16'h7F80, 16'h3B80, 16'h3C00}, 0);
    drain();

    // Random traffic with random backpressure and input gaps.
    for (int n = 0; n < 200; n++) drive_vec(gen_vec(), 3);
    drain();

    // Stall: 6 vectors offered with out_ready low.
    for (int k = 0; k < 6; k++) svec[k] = gen_vec();
    c0 = out_count;
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data = svec[acc % 6];
      in_tag = tag_ctr;
      @(negedge clk);
      if (in_ready) begin
        acc++;
        tag_ctr++;
      end
      @(posedge clk); #1;
    end
    check("stall_accepted", 64'(acc), 64'd3);
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_full", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    for (int k = acc; k < 6; k++) drive_vec(svec[k], 0);
    drain();
    check("stall_out_count", 64'(out_count - c0), 64'd6);

    // Toggle out_ready every cycle over 20 vectors.
    c0 = out_count;
    for (int n = 0; n < 20; n++) drive_vec(gen_vec(), 2);
    drain();
    check("toggle_out_count", 64'(out_count - c0), 64'd20);

    // Reset with two vectors in flight.
    c0 = out_count;
    drive_vec(gen_vec(), 0);
    drive_vec(gen_vec(), 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_emit", 64'(out_count - c0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
